// File: rtl/hp_mul_sched.sv
// Round-robin scheduler in front of a shared combinational half-precision
// multiply core. Two clients hand over operand pairs, the block drives the
// core for CORE_LAT cycles, then captures and returns the tagged result.
//
// Handshake rule on every port: a transfer happens on a rising edge where
// valid and ready are both high. A requester keeps valid and its operands
// steady until it sees ready. res_valid stays high with res_* frozen until
// res_ready is seen.
module hp_mul_sched #(
  parameter int CORE_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic [15:0] core_a,
  output logic [15:0] core_b,
  input  logic        core_sign,
  input  logic [4:0]  core_exp,
  input  logic [19:0] core_mant,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic        res_sign,
  output logic [4:0]  res_exp,
  output logic [19:0] res_mant,
  output logic        busy,
  output logic [15:0] ops_count
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  // The counter only counts down from CORE_LAT-1, so four bits cover 1..15.
  localparam logic [3:0] CNT_LOAD = 4'(CORE_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        tag;
  logic        last_grant;
  logic        grant;
  logic        accept;
  logic        capture;
  logic        done;
  logic [15:0] ops_q;

  // Arbitration: a lone requester wins; on contention the one not served last.
  always_comb begin
    grant = last_grant;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else if (req0_valid && req1_valid) begin
      grant = !last_grant;
    end
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign capture    = (state == CALC) && (cnt == 4'd0);
  assign done       = (state == HOLD) && res_valid && res_ready;
  assign busy       = (state != IDLE);
  assign ops_count  = ops_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept -> count down core latency -> hold result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: if (capture) state_nxt = HOLD;
      HOLD: if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand launch, latency counter, result capture and op count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= 4'd0;
      tag        <= 1'b0;
      last_grant <= 1'b1;
      core_a     <= 16'd0;
      core_b     <= 16'd0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_sign   <= 1'b0;
      res_exp    <= 5'd0;
      res_mant   <= 20'd0;
      ops_q      <= 16'd0;
    end else begin
      if (accept) begin
        core_a     <= grant ? req1_a : req0_a;
        core_b     <= grant ? req1_b : req0_b;
        tag        <= grant;
        last_grant <= grant;
        cnt        <= CNT_LOAD;
      end
      if (state == CALC) begin
        if (capture) begin
          res_sign  <= core_sign;
          res_exp   <= core_exp;
          res_mant  <= core_mant;
          res_id    <= tag;
          res_valid <= 1'b1;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
      if (done) begin
        res_valid <= 1'b0;
        ops_q     <= ops_q + 16'd1;
      end
    end
  end

endmodule
